exe_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EXE stage of the five-stage pipeline. It replaces the separate fixed-width multiplier and divider with one shared datapath. It adds a valid/ready handshake on both sides, a configurable multiply step, a synchronous cancel for exception flushes, and divide-by-zero reporting. Results go out as a HI/LO pair: product high/low for multiply, remainder/quotient for divide.

---
 rtl/exe_muldiv_unit_if.sv | 26 ++
 rtl/exe_muldiv_unit.sv | 121 ++++++++++++
 tb/tb_exe_muldiv_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_unit_if.sv
// Request/response bundle between the EXE stage and the shared multiply/divide unit.
interface exe_muldiv_unit_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic             in_div;
   logic             in_sign;
   logic [WIDTH-1:0] in_src1;
   logic [WIDTH-1:0] in_src2;
   logic             cancel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_hi;
   logic [WIDTH-1:0] out_lo;
   logic             out_div0;
   logic             busy;

   modport master (
      output in_valid, in_div, in_sign, in_src1, in_src2, cancel, out_ready,
      input  in_ready, out_valid, out_hi, out_lo, out_div0, busy
   );

   modport slave (
      input  in_valid, in_div, in_sign, in_src1, in_src2, cancel, out_ready,
      output in_ready, out_valid, out_hi, out_lo, out_div0, busy
   );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one 2W-bit working register.
// Results are HI/LO: product high/low, or remainder/quotient.
module exe_muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 2
) (
   input logic               clk,
   input logic               resetn,
   exe_muldiv_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   opb;
   logic [CW-1:0]      cnt;
   logic               psign, rsign, dz;
   logic [WIDTH-1:0]   hi, lo;
   logic               div0;

   logic               s1, s2;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH+MUL_STEP-1:0] pp, msum;
   logic [2*WIDTH-1:0] mul_next, mul_res, div_next;
   logic [WIDTH:0]     dtrial, diff;

   assign bus.in_ready  = (state == IDLE) & ~bus.cancel;
   assign bus.busy      = (state == MUL) | (state == DIV);
   assign bus.out_valid = (state == DONE);
   assign bus.out_hi    = hi;
   assign bus.out_lo    = lo;
   assign bus.out_div0  = div0;

   always_comb begin
      s1   = bus.in_sign & bus.in_src1[WIDTH-1];
      s2   = bus.in_sign & bus.in_src2[WIDTH-1];
      mag1 = s1 ? -bus.in_src1 : bus.in_src1;
      mag2 = s2 ? -bus.in_src2 : bus.in_src2;

      // prod = {partial, multiplier}; retire MUL_STEP low bits per cycle and shift right
      pp = '0;
      for (int i = 0; i < MUL_STEP; i++)
         if (prod[i]) pp = pp + ({{MUL_STEP{1'b0}}, opb} << i);
      msum     = {{MUL_STEP{1'b0}}, prod[2*WIDTH-1:WIDTH]} + pp;
      mul_next = {msum, prod[WIDTH-1:MUL_STEP]};
      mul_res  = psign ? -mul_next : mul_next;

      // prod = {remainder, dividend/quotient}; one restoring step per cycle
      dtrial   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      diff     = dtrial - {1'b0, opb};
      div_next = diff[WIDTH] ? {dtrial[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0],   prod[WIDTH-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         prod  <= '0;
         opb   <= '0;
         cnt   <= '0;
         psign <= 1'b0;
         rsign <= 1'b0;
         dz    <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         div0  <= 1'b0;
      end else if (bus.cancel) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               psign <= s1 ^ s2;
               rsign <= s1;
               if (bus.in_div) begin
                  state <= DIV;
                  opb   <= mag2;
                  // zero divisor: one DIV cycle that only publishes the raw dividend
                  dz    <= (bus.in_src2 == '0);
                  prod  <= {{WIDTH{1'b0}}, (bus.in_src2 == '0) ? bus.in_src1 : mag1};
                  cnt   <= (bus.in_src2 == '0) ? CW'(1) : CW'(WIDTH);
               end else begin
                  state <= MUL;
                  opb   <= mag1;
                  dz    <= 1'b0;
                  prod  <= {{WIDTH{1'b0}}, mag2};
                  cnt   <= CW'(WIDTH / MUL_STEP);
               end
            end
            MUL: begin
               prod <= mul_next;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  {hi, lo} <= mul_res;
                  div0     <= 1'b0;
                  state    <= DONE;
               end
            end
            DIV: begin
               prod <= div_next;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= DONE;
                  if (dz) begin
                     hi   <= prod[WIDTH-1:0];
                     lo   <= '1;
                     div0 <= 1'b1;
                  end else begin
                     lo   <= psign ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
                     hi   <= rsign ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
                     div0 <= 1'b0;
                  end
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench: one unit per MUL_STEP (2, 1, 4) fed the same requests.
module tb_exe_muldiv_unit;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   exe_muldiv_unit_if #(.WIDTH(32)) bus ();
   exe_muldiv_unit_if #(.WIDTH(32)) bus1 ();
   exe_muldiv_unit_if #(.WIDTH(32)) bus4 ();

   exe_muldiv_unit #(.WIDTH(32), .MUL_STEP(2)) dut  (.clk(clk), .resetn(resetn), .bus(bus.slave));
   exe_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1.slave));
   exe_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4.slave));

   assign bus1.in_valid  = bus.in_valid;   assign bus4.in_valid  = bus.in_valid;
   assign bus1.in_div    = bus.in_div;     assign bus4.in_div    = bus.in_div;
   assign bus1.in_sign   = bus.in_sign;    assign bus4.in_sign   = bus.in_sign;
   assign bus1.in_src1   = bus.in_src1;    assign bus4.in_src1   = bus.in_src1;
   assign bus1.in_src2   = bus.in_src2;    assign bus4.in_src2   = bus.in_src2;
   assign bus1.cancel    = bus.cancel;     assign bus4.cancel    = bus.cancel;
   assign bus1.out_ready = bus.out_ready;  assign bus4.out_ready = bus.out_ready;

   logic [2:0]  ovs, odz;
   logic [31:0] ohi [3];
   logic [31:0] olo [3];
   assign ovs = {bus4.out_valid, bus1.out_valid, bus.out_valid};
   assign odz = {bus4.out_div0, bus1.out_div0, bus.out_div0};
   assign ohi[0] = bus.out_hi;  assign ohi[1] = bus1.out_hi;  assign ohi[2] = bus4.out_hi;
   assign olo[0] = bus.out_lo;  assign olo[1] = bus1.out_lo;  assign olo[2] = bus4.out_lo;

   int total = 0;
   int bad = 0;
   int          lat [3];
   logic [31:0] rhi [3];
   logic [31:0] rlo [3];
   logic        rdz [3];
   int          exp_mlat [3] = '{16, 32, 8};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Issue one request while idle, then record latency and result of each unit.
   task automatic do_op(input logic dv, input logic sg, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_div = dv; bus.in_sign = sg;
      bus.in_src1 = a; bus.in_src2 = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) lat[k] = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            if (lat[k] < 0 && ovs[k]) begin
               lat[k] = c - 1; rhi[k] = ohi[k]; rlo[k] = olo[k]; rdz[k] = odz[k];
            end
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int unstable, rdy_seen, vld_lost, late;
      bus.in_valid = 1'b0; bus.in_div = 1'b0; bus.in_sign = 1'b0;
      bus.in_src1 = '0; bus.in_src2 = '0; bus.cancel = 1'b0; bus.out_ready = 1'b1;

      #3;
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_busy",      64'(bus.busy),      64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_hi",        64'(bus.out_hi),    64'd0);
      chk("rst_lo",        64'(bus.out_lo),    64'd0);
      chk("rst_div0",      64'(bus.out_div0),  64'd0);
      @(negedge clk) resetn = 1'b1;

      do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("umul_hi_%0d", k),  64'(rhi[k]), 64'hFFFFFFFE);
         chk($sformatf("umul_lo_%0d", k),  64'(rlo[k]), 64'h00000001);
         chk($sformatf("umul_lat_%0d", k), 64'(lat[k]), 64'(exp_mlat[k]));
      end
      chk("umul_div0", 64'(rdz[0]), 64'd0);

      do_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd3);
      chk("smul_hi",    64'(rhi[0]), 64'hFFFFFFFF);
      chk("smul_lo",    64'(rlo[0]), 64'hFFFFFFEB);
      chk("smul_lo_s4", 64'(rlo[2]), 64'hFFFFFFEB);

      do_op(1'b0, 1'b1, 32'h80000000, 32'h80000000);
      chk("smul_min_hi", 64'(rhi[0]), 64'h40000000);
      chk("smul_min_lo", 64'(rlo[0]), 64'h00000000);

      do_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
      chk("sdiv_lo",   64'(rlo[0]), 64'hFFFFFFFD);
      chk("sdiv_hi",   64'(rhi[0]), 64'hFFFFFFFF);
      chk("sdiv_div0", 64'(rdz[0]), 64'd0);
      chk("sdiv_lat",  64'(lat[0]), 64'd32);

      do_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
      chk("sdiv_ovf_lo", 64'(rlo[0]), 64'h80000000);
      chk("sdiv_ovf_hi", 64'(rhi[0]), 64'h00000000);

      do_op(1'b1, 1'b0, 32'h00001234, 32'd0);
      chk("dz_lat",  64'(lat[0]), 64'd1);
      chk("dz_lo",   64'(rlo[0]), 64'hFFFFFFFF);
      chk("dz_hi",   64'(rhi[0]), 64'h00001234);
      chk("dz_div0", 64'(rdz[0]), 64'd1);

      do_op(1'b1, 1'b1, 32'hFFFFFFFB, 32'd0);
      chk("dz_neg_hi",   64'(rhi[0]), 64'hFFFFFFFB);
      chk("dz_neg_div0", 64'(rdz[0]), 64'd1);

      // cancel a divide after ten iterations
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_div = 1'b1; bus.in_sign = 1'b0;
      bus.in_src1 = 32'd1000; bus.in_src2 = 32'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("cxl_busy_before", 64'(bus.busy), 64'd1);
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      @(negedge clk);
      chk("cxl_busy",     64'(bus.busy),      64'd0);
      chk("cxl_valid",    64'(bus.out_valid), 64'd0);
      chk("cxl_in_ready", 64'(bus.in_ready),  64'd1);
      late = 0;
      repeat (40) @(negedge clk) if (ovs != 3'b000) late++;
      chk("cxl_no_result", 64'(late), 64'd0);

      do_op(1'b0, 1'b0, 32'd3, 32'd5);
      chk("post_cxl_lo",   64'(rlo[0]), 64'd15);
      chk("post_cxl_hi",   64'(rhi[0]), 64'd0);
      chk("post_cxl_div0", 64'(rdz[0]), 64'd0);
      chk("post_cxl_lat",  64'(lat[0]), 64'd16);

      // cancel coincident with a request in IDLE
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.cancel = 1'b1; bus.in_div = 1'b0;
      bus.in_src1 = 32'd3; bus.in_src2 = 32'd5;
      @(negedge clk);
      chk("cxl_idle_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.cancel = 1'b0;
      @(negedge clk);
      chk("cxl_idle_busy",  64'(bus.busy),      64'd0);
      chk("cxl_idle_valid", 64'(bus.out_valid), 64'd0);

      // backpressure: hold the result for 20 cycles while a request is pulsed
      bus.out_ready = 1'b0;
      do_op(1'b0, 1'b1, 32'hFFFFFFFA, 32'd7);
      chk("bp_hi", 64'(rhi[0]), 64'hFFFFFFFF);
      chk("bp_lo", 64'(rlo[0]), 64'hFFFFFFD6);
      unstable = 0; rdy_seen = 0; vld_lost = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ohi[0] !== 32'hFFFFFFFF || olo[0] !== 32'hFFFFFFD6 || odz[0] !== 1'b0) unstable++;
         if (bus.in_ready) rdy_seen++;
         if (!bus.out_valid) vld_lost++;
         if (i == 5) begin
            bus.in_valid = 1'b1; bus.in_div = 1'b1; bus.in_src1 = 32'd9; bus.in_src2 = 32'd0;
         end
         if (i == 7) bus.in_valid = 1'b0;
      end
      chk("bp_stable",   64'(unstable), 64'd0);
      chk("bp_in_ready", 64'(rdy_seen), 64'd0);
      chk("bp_valid",    64'(vld_lost), 64'd0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_release_busy",  64'(bus.busy),      64'd0);
      chk("bp_release_ready", 64'(bus.in_ready),  64'd1);
      chk("bp_release_lo",    64'(bus.out_lo),    64'hFFFFFFD6);
      chk("bp_release_div0",  64'(bus.out_div0),  64'd0);

      // asynchronous reset mid-multiply
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_div = 1'b0; bus.in_sign = 1'b0;
      bus.in_src1 = 32'h0000FFFF; bus.in_src2 = 32'h0000FFFF;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_busy",  64'(bus.busy),      64'd0);
      chk("arst_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_hi",    64'(bus.out_hi),    64'd0);
      chk("arst_lo",    64'(bus.out_lo),    64'd0);
      chk("arst_div0",  64'(bus.out_div0),  64'd0);
      chk("arst_ready", 64'(bus.in_ready),  64'd1);
      @(negedge clk) resetn = 1'b1;
      late = 0;
      repeat (40) @(negedge clk) if (ovs != 3'b000) late++;
      chk("arst_no_result", 64'(late), 64'd0);

      do_op(1'b1, 1'b0, 32'd100, 32'd7);
      chk("udiv_lo", 64'(rlo[0]), 64'd14);
      chk("udiv_hi", 64'(rhi[0]), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
